loot_collector: RTL

//  Claw-side consumer of the loot matrix's caught-loot report. Latches the loot type hooked by
//  the claw, sets the claw retract speed by loot weight, and banks the loot value into the

---
 rtl/loot_collector.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/loot_collector.sv
// loot_collector
//   Claw-side consumer of the caught-loot report. It latches the loot the claw
//   has hooked and sets the retract speed from the loot's weight. When the claw
//   gets home it banks the loot value into a saturating score, shows that value
//   in a popup for a fixed number of video frames, and keeps count of the loot
//   left on the map so it can flag the end of the level.
//
//   Optional feature: define LOOT_DROP_EN to let the player discard the carried
//   loot with loot_drop. The loot counts as gone from the map but scores nothing.
//
// Ports
//   clk               in   system clock
//   reset             in   synchronous, active-high reset
//   start_level       in   1-clk pulse, new level begins
//   level_num         in   [2:0] level index, 1-based (level 1 clears the score)
//   level_loot_total  in   [6:0] loot placed on the map, sampled on start_level
//   start_of_frame    in   1-clk pulse per video frame
//   caught_loot_type  in   [2:0] nonzero for one clk when the claw hits loot
//   claw_home         in   high while the claw is retracted at its origin
//   loot_drop         in   discard carried loot (LOOT_DROP_EN builds only)
//   carried_loot_type out  [2:0] loot on the claw, 0 = none
//   pull_speed        out  [2:0] retract speed: 4 none, 2 gold, 1 rock, 3 diamond/goblet
//   score             out  [15:0] cumulative, saturating score
//   popup_value       out  [15:0] value of the last banked loot
//   popup_valid       out  high while the popup is shown
//   loot_remaining    out  [6:0] loot still on the map
//   level_cleared     out  high once the level has been cleared
//
// state      | meaning
// IDLE_ST    | out of reset, waiting for the first start_level
// EMPTY_ST   | claw free, waiting for a catch
// CARRY_ST   | loot on the claw, waiting for the claw to reach home
// CASH_ST    | loot banked, popup shown for CASH_FRAMES frames
// CLEARED_ST | no loot left, waiting for start_level
module loot_collector #(
  parameter logic [15:0] VAL_GOLD    = 16'd50,
  parameter logic [15:0] VAL_ROCK    = 16'd10,
  parameter logic [15:0] VAL_DIAMOND = 16'd200,
  parameter logic [15:0] VAL_GOBLET  = 16'd500,
  parameter logic [5:0]  CASH_FRAMES = 6'd30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_level,
  input  logic [2:0]  level_num,
  input  logic [6:0]  level_loot_total,
  input  logic        start_of_frame,
  input  logic [2:0]  caught_loot_type,
  input  logic        claw_home,
  input  logic        loot_drop,
  output logic [2:0]  carried_loot_type,
  output logic [2:0]  pull_speed,
  output logic [15:0] score,
  output logic [15:0] popup_value,
  output logic        popup_valid,
  output logic [6:0]  loot_remaining,
  output logic        level_cleared
);

  typedef enum logic [2:0] {
    IDLE_ST, EMPTY_ST, CARRY_ST, CASH_ST, CLEARED_ST
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  carried_nxt, speed_nxt;
  logic [15:0] score_nxt, popup_nxt;
  logic [6:0]  remaining_nxt, remaining_dec;
  logic [5:0]  frame_cnt, frame_nxt;
  logic [16:0] score_sum;

  function automatic logic [15:0] loot_value(input logic [2:0] t);
    case (t)
      3'd1:    loot_value = VAL_GOLD;
      3'd2:    loot_value = VAL_ROCK;
      3'd3:    loot_value = VAL_DIAMOND;
      3'd4:    loot_value = VAL_GOBLET;
      default: loot_value = 16'd0;
    endcase
  endfunction

  // Heavier loot pulls back slower; unknown types behave like an empty claw.
  function automatic logic [2:0] loot_speed(input logic [2:0] t);
    case (t)
      3'd1:      loot_speed = 3'd2;
      3'd2:      loot_speed = 3'd1;
      3'd3, 3'd4: loot_speed = 3'd3;
      default:   loot_speed = 3'd4;
    endcase
  endfunction

  assign score_sum     = {1'b0, score} + {1'b0, loot_value(carried_loot_type)};
  assign remaining_dec = (loot_remaining == 7'd0) ? 7'd0 : loot_remaining - 7'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE_ST;
      carried_loot_type <= 3'd0;
      pull_speed        <= 3'd4;
      score             <= 16'd0;
      popup_value       <= 16'd0;
      loot_remaining    <= 7'd0;
      frame_cnt         <= 6'd0;
    end else begin
      state             <= state_nxt;
      carried_loot_type <= carried_nxt;
      pull_speed        <= speed_nxt;
      score             <= score_nxt;
      popup_value       <= popup_nxt;
      loot_remaining    <= remaining_nxt;
      frame_cnt         <= frame_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    carried_nxt   = carried_loot_type;
    speed_nxt     = pull_speed;
    score_nxt     = score;
    popup_nxt     = popup_value;
    remaining_nxt = loot_remaining;
    frame_nxt     = frame_cnt;

    if (start_level) begin
      // A new level overrides whatever the claw was doing.
      remaining_nxt = level_loot_total;
      carried_nxt   = 3'd0;
      speed_nxt     = 3'd4;
      frame_nxt     = 6'd0;
      if (level_num == 3'd1) score_nxt = 16'd0;
      state_nxt     = (level_loot_total == 7'd0) ? CLEARED_ST : EMPTY_ST;
    end else begin
      case (state)
        IDLE_ST: ;
        EMPTY_ST: begin
          if (caught_loot_type != 3'd0) begin
            carried_nxt = caught_loot_type;
            speed_nxt   = loot_speed(caught_loot_type);
            state_nxt   = CARRY_ST;
          end
        end
        CARRY_ST: begin
          if (claw_home) begin
            popup_nxt     = loot_value(carried_loot_type);
            score_nxt     = score_sum[16] ? 16'hFFFF : score_sum[15:0];
            remaining_nxt = remaining_dec;
            carried_nxt   = 3'd0;
            speed_nxt     = 3'd4;
            frame_nxt     = 6'd0;
            state_nxt     = CASH_ST;
          end
`ifdef LOOT_DROP_EN
          else if (loot_drop) begin
            carried_nxt   = 3'd0;
            speed_nxt     = 3'd4;
            remaining_nxt = remaining_dec;
            state_nxt     = (remaining_dec == 7'd0) ? CLEARED_ST : EMPTY_ST;
          end
`endif
        end
        CASH_ST: begin
          if (start_of_frame) begin
            if (frame_cnt == CASH_FRAMES - 6'd1) begin
              frame_nxt = 6'd0;
              state_nxt = (loot_remaining == 7'd0) ? CLEARED_ST : EMPTY_ST;
            end else begin
              frame_nxt = frame_cnt + 6'd1;
            end
          end
        end
        CLEARED_ST: ;
        default: state_nxt = IDLE_ST;
      endcase
    end
  end

`ifndef LOOT_DROP_EN
  logic drop_unused;
  assign drop_unused = loot_drop;
`endif

  assign popup_valid   = (state == CASH_ST);
  assign level_cleared = (state == CLEARED_ST);

endmodule
